// File: rtl/div_unit.sv
// Sequential unsigned non-restoring divider: 2*WIDTH-bit dividend over WIDTH-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module div_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_dvd_hi,
  input  logic             load_dvd_lo,
  input  logic             load_dvs,
  input  logic             start_div,
  output logic             dividend_ready,
  output logic             busy,
  output logic             done_div,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StIter, StCorrect, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_hi_q, dvd_hi_d;
  logic [WIDTH-1:0] dvd_lo_q, dvd_lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             hi_loaded_q, hi_loaded_d;
  logic             lo_loaded_q, lo_loaded_d;
  logic [WIDTH+1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] rem_fix;
  logic [WIDTH+1:0] dvs_ext;

  assign dvs_ext = {2'b00, dvs_q};

  always_comb begin
    state_d     = state_q;
    dvd_hi_d    = dvd_hi_q;
    dvd_lo_d    = dvd_lo_q;
    dvs_d       = dvs_q;
    hi_loaded_d = hi_loaded_q;
    lo_loaded_d = lo_loaded_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    shifted     = {rem_q[WIDTH:0], q_q[WIDTH-1]};
    rem_fix     = rem_q[WIDTH+1] ? (rem_q + dvs_ext) : rem_q;

    unique case (state_q)
      StIdle: begin
        if (load_dvd_hi) begin
          dvd_hi_d    = data_in;
          hi_loaded_d = 1'b1;
        end
        if (load_dvd_lo) begin
          dvd_lo_d    = data_in;
          lo_loaded_d = 1'b1;
        end
        if (load_dvs) begin
          dvs_d = data_in;
        end
        if (start_div && hi_loaded_q && lo_loaded_q) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (dvs_q == '0) begin
            dbz_d   = 1'b1;
            quot_d  = '1;
            rmd_d   = dvd_hi_q;
            state_d = StDone;
          end else if (dvd_hi_q >= dvs_q) begin
            // Quotient would need more than WIDTH bits
            ovf_d   = 1'b1;
            quot_d  = '1;
            rmd_d   = dvd_hi_q;
            state_d = StDone;
          end else begin
            rem_d   = {2'b00, dvd_hi_q};
            q_d     = dvd_lo_q;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StIter;
          end
        end
      end
      StIter: begin
        // Sign of the pre-shift partial remainder selects subtract or add-back
        rem_d = rem_q[WIDTH+1] ? (shifted + dvs_ext) : (shifted - dvs_ext);
        q_d   = {q_q[WIDTH-2:0], ~rem_d[WIDTH+1]};
        if (cnt_q == '0) begin
          state_d = StCorrect;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCorrect: begin
        rem_d   = rem_fix;
        quot_d  = q_q;
        rmd_d   = rem_fix[WIDTH-1:0];
        state_d = StDone;
      end
      StDone: begin
        hi_loaded_d = 1'b0;
        lo_loaded_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      dvd_hi_q    <= '0;
      dvd_lo_q    <= '0;
      dvs_q       <= '0;
      hi_loaded_q <= 1'b0;
      lo_loaded_q <= 1'b0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_hi_q    <= dvd_hi_d;
      dvd_lo_q    <= dvd_lo_d;
      dvs_q       <= dvs_d;
      hi_loaded_q <= hi_loaded_d;
      lo_loaded_q <= lo_loaded_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rmd_q       <= rmd_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign dividend_ready = hi_loaded_q & lo_loaded_q;
  assign busy           = (state_q != StIdle);
  assign done_div       = (state_q == StDone);
  assign quotient       = quot_q;
  assign remainder      = rmd_q;
  assign div_by_zero    = dbz_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random operands checked against an
// arithmetic reference model (integer divide/modulo and the error rules).
module tb_div_unit;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_dvd_hi;
  logic       load_dvd_lo;
  logic       load_dvs;
  logic       start_div;
  logic       dividend_ready;
  logic       busy;
  logic       done_div;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] prev_q = 8'h00;
  logic [7:0] prev_r = 8'h00;

  div_unit #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .load_dvd_hi   (load_dvd_hi),
    .load_dvd_lo   (load_dvd_lo),
    .load_dvs      (load_dvs),
    .start_div     (start_div),
    .dividend_ready(dividend_ready),
    .busy          (busy),
    .done_div      (done_div),
    .quotient      (quotient),
    .remainder     (remainder),
    .div_by_zero   (div_by_zero),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dvs);
    data_in = hi; load_dvd_hi = 1'b1; tick(); load_dvd_hi = 1'b0;
    data_in = lo; load_dvd_lo = 1'b1; tick(); load_dvd_lo = 1'b0;
    data_in = dvs; load_dvs = 1'b1; tick(); load_dvs = 1'b0;
  endtask

  // Starts a divide on already-loaded operands and checks latency and results.
  task automatic run_div(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [7:0] dvs, input bit inject);
    int exp_lat;
    int cnt;
    int dvd;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic exp_dbz;
    logic exp_ovf;
    dvd = {16'h0, hi, lo};
    exp_dbz = 1'b0;
    exp_ovf = 1'b0;
    if (dvs == 8'h00) begin
      exp_dbz = 1'b1; exp_q = 8'hFF; exp_r = hi; exp_lat = 1;
    end else if (hi >= dvs) begin
      exp_ovf = 1'b1; exp_q = 8'hFF; exp_r = hi; exp_lat = 1;
    end else begin
      exp_q = 8'(dvd / int'(dvs)); exp_r = 8'(dvd % int'(dvs)); exp_lat = 10;
    end
    check_eq({tag, " ready_before"}, 32'(dividend_ready), 32'd1);
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    cnt = 1;
    while (!done_div && cnt < 40) begin
      if (cnt == 5) begin
        check_eq({tag, " busy_mid"}, 32'(busy), 32'd1);
        check_eq({tag, " q_hold"}, 32'(quotient), 32'(prev_q));
        check_eq({tag, " r_hold"}, 32'(remainder), 32'(prev_r));
      end
      if (inject && cnt == 3) begin
        data_in = 8'h01; load_dvs = 1'b1; start_div = 1'b1;
      end else begin
        load_dvs = 1'b0; start_div = 1'b0;
      end
      tick();
      cnt++;
    end
    load_dvs = 1'b0;
    start_div = 1'b0;
    check_eq({tag, " done"}, 32'(done_div), 32'd1);
    check_eq({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    check_eq({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check_eq({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check_eq({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    check_eq({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    tick();
    check_eq({tag, " done_pulse"}, 32'(done_div), 32'd0);
    check_eq({tag, " ready_after"}, 32'(dividend_ready), 32'd0);
    check_eq({tag, " flag_sticky"}, 32'({div_by_zero, overflow}), 32'({exp_dbz, exp_ovf}));
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  initial begin
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] dvs;
    reset = 1'b0;
    data_in = 8'h00;
    load_dvd_hi = 1'b0;
    load_dvd_lo = 1'b0;
    load_dvs = 1'b0;
    start_div = 1'b0;
    #1;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done_div), 32'd0);
    check_eq("rst ready", 32'(dividend_ready), 32'd0);
    check_eq("rst q", 32'(quotient), 32'd0);
    check_eq("rst r", 32'(remainder), 32'd0);
    check_eq("rst flags", 32'({div_by_zero, overflow}), 32'd0);
    #11;
    reset = 1'b1;
    tick();

    load_ops(8'h03, 8'hE8, 8'h07);
    run_div("basic", 8'h03, 8'hE8, 8'h07, 1'b0);
    load_ops(8'hFE, 8'hFF, 8'hFF);
    run_div("maxdvd", 8'hFE, 8'hFF, 8'hFF, 1'b0);
    load_ops(8'h12, 8'h34, 8'h00);
    run_div("dbz", 8'h12, 8'h34, 8'h00, 1'b0);
    load_ops(8'h07, 8'h00, 8'h07);
    run_div("ovf", 8'h07, 8'h00, 8'h07, 1'b0);
    load_ops(8'h01, 8'h00, 8'h03);
    run_div("ovf_clear", 8'h01, 8'h00, 8'h03, 1'b0);

    // Both dividend halves captured from one bus value in the same cycle
    data_in = 8'h02; load_dvd_hi = 1'b1; load_dvd_lo = 1'b1; tick();
    load_dvd_hi = 1'b0; load_dvd_lo = 1'b0;
    data_in = 8'h09; load_dvs = 1'b1; tick(); load_dvs = 1'b0;
    run_div("joint", 8'h02, 8'h02, 8'h09, 1'b0);

    // Handshake: start before the low half is present must be ignored
    data_in = 8'h05; load_dvd_hi = 1'b1; tick(); load_dvd_hi = 1'b0;
    check_eq("hs ready_hi_only", 32'(dividend_ready), 32'd0);
    start_div = 1'b1; tick(); start_div = 1'b0;
    check_eq("hs busy_ignored", 32'(busy), 32'd0);
    tick();
    check_eq("hs busy_still", 32'(busy), 32'd0);
    data_in = 8'h21; load_dvd_lo = 1'b1;
    #1;
    check_eq("hs ready_not_yet", 32'(dividend_ready), 32'd0);
    tick(); load_dvd_lo = 1'b0;
    check_eq("hs ready_rise", 32'(dividend_ready), 32'd1);
    data_in = 8'h0D; load_dvs = 1'b1; tick(); load_dvs = 1'b0;
    run_div("hs inject", 8'h05, 8'h21, 8'h0D, 1'b1);

    // Reset in the fourth ITER cycle aborts without a completion pulse
    load_ops(8'h03, 8'hE8, 8'h07);
    start_div = 1'b1; tick(); start_div = 1'b0;
    tick(); tick(); tick();
    check_eq("mid busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid busy", 32'(busy), 32'd0);
    check_eq("mid q", 32'(quotient), 32'd0);
    check_eq("mid r", 32'(remainder), 32'd0);
    check_eq("mid ready", 32'(dividend_ready), 32'd0);
    check_eq("mid flags", 32'({div_by_zero, overflow}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mid no_done", 32'(done_div), 32'd0);
    end
    reset = 1'b1;
    prev_q = 8'h00;
    prev_r = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_div) check_eq("mid stray_done", 32'(done_div), 32'd0);
    end
    load_ops(8'h00, 8'h64, 8'h09);
    run_div("post_rst", 8'h00, 8'h64, 8'h09, 1'b0);

    for (int n = 0; n < 40; n++) begin
      dvs = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      if (dvs != 8'h00 && $urandom_range(0, 5) != 0) hi = 8'($urandom_range(0, int'(dvs) - 1));
      else hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      load_ops(hi, lo, dvs);
      run_div("rand", hi, lo, dvs, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
